// File: rtl/ej32_dstack.sv
// ---------------------------------------------------------------------------
// ej32_dstack -- parametrised data-stack engine for the eJ32 core.
//
// The top two entries (TOS, NOS) live in registers. Deeper entries live in an
// array of SS_DEPTH-2 words indexed by sp, the next free slot. The array read
// is combinational, so every op completes in one cycle with no bubbles.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   op_valid  in   op request
//   op_ready  out  engine accepts the op (accepted = op_valid && op_ready)
//   op        in   0 NOP, 1 PUSH, 2 POP, 3 ALU, 4 REPL, 5 SWAP, 6 DUP, 7 OVER
//   din       in   push value or ALU result
//   err_clr   in   clears the sticky ovf/udf flags
//   tos, nos  out  registered top / next-of-stack
//   depth     out  live entry count, 0..SS_DEPTH
//   hwm       out  maximum depth reached since reset
//   full      out  depth == SS_DEPTH
//   empty     out  depth == 0
//   ovf, udf  out  sticky overflow / underflow flags
// ---------------------------------------------------------------------------
module ej32_dstack #(
    parameter int DSZ         = 32,
    parameter int SS_DEPTH    = 32,
    parameter int HALT_ON_ERR = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [2:0]                op,
    input  logic [DSZ-1:0]            din,
    input  logic                      err_clr,
    output logic [DSZ-1:0]            tos,
    output logic [DSZ-1:0]            nos,
    output logic [$clog2(SS_DEPTH):0] depth,
    output logic [$clog2(SS_DEPTH):0] hwm,
    output logic                      full,
    output logic                      empty,
    output logic                      ovf,
    output logic                      udf
);

    localparam int AW    = $clog2(SS_DEPTH);
    localparam int DW    = AW + 1;
    localparam int ARR_N = SS_DEPTH - 2;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_ALU  = 3'd3;
    localparam logic [2:0] OP_REPL = 3'd4;
    localparam logic [2:0] OP_SWAP = 3'd5;
    localparam logic [2:0] OP_DUP  = 3'd6;
    localparam logic [2:0] OP_OVER = 3'd7;

    localparam logic [DW-1:0] D_ZERO = '0;
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_TWO  = DW'(2);
    localparam logic [DW-1:0] D_FULL = DW'(SS_DEPTH);

    generate
        if (SS_DEPTH < 4 || (SS_DEPTH & (SS_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("ej32_dstack: SS_DEPTH must be a power of 2 and >= 4");
        end
        if (DSZ < 8) begin : g_bad_width
            $error("ej32_dstack: DSZ must be >= 8");
        end
    endgenerate

    // Minimum live depth each op needs before it may execute.
    function automatic logic [DW-1:0] min_depth(input logic [2:0] o);
        case (o)
            OP_POP, OP_REPL, OP_DUP: min_depth = D_ONE;
            OP_ALU, OP_SWAP, OP_OVER: min_depth = D_TWO;
            default:                  min_depth = D_ZERO;
        endcase
    endfunction

    function automatic logic [DW-1:0] max_depth(input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        max_depth = (a > b) ? a : b;
    endfunction

    logic [DSZ-1:0] arr [ARR_N];
    logic [AW-1:0]  sp;
    logic [AW-1:0]  sp_nxt;
    logic [AW-1:0]  rd_idx;
    logic [DSZ-1:0] arr_rd;
    logic           arr_we;

    logic [DSZ-1:0] tos_nxt;
    logic [DSZ-1:0] nos_nxt;
    logic [DSZ-1:0] push_val;
    logic [DW-1:0]  depth_nxt;
    logic           accept;
    logic           is_push;
    logic           ovf_hit;
    logic           udf_hit;

    assign op_ready = (HALT_ON_ERR != 0) ? !(ovf || udf) : 1'b1;
    assign accept   = op_valid && op_ready;
    assign is_push  = (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
    assign full     = (depth == D_FULL);
    assign empty    = (depth == D_ZERO);

    // The entry just below NOS. Only consumed when depth >= 3, which implies
    // sp >= 1; the clamp keeps the index in range when the stack is shallow.
    assign rd_idx = (sp == '0) ? '0 : (sp - 1'b1);
    assign arr_rd = arr[rd_idx];

    always_comb begin
        tos_nxt   = tos;
        nos_nxt   = nos;
        depth_nxt = depth;
        sp_nxt    = sp;
        arr_we    = 1'b0;
        push_val  = din;
        ovf_hit   = 1'b0;
        udf_hit   = 1'b0;

        if (accept) begin
            if (is_push && depth == D_FULL) begin
                ovf_hit = 1'b1;
            end else if (depth < min_depth(op)) begin
                udf_hit = 1'b1;
            end else begin
                case (op)
                    OP_PUSH, OP_DUP, OP_OVER: begin
                        if (op == OP_DUP)       push_val = tos;
                        else if (op == OP_OVER) push_val = nos;
                        else                    push_val = din;
                        // NOS spills into the array only once it holds a live value.
                        if (depth >= D_TWO) begin
                            arr_we = 1'b1;
                            sp_nxt = sp + 1'b1;
                        end
                        nos_nxt   = tos;
                        tos_nxt   = push_val;
                        depth_nxt = depth + D_ONE;
                    end
                    OP_POP, OP_ALU: begin
                        if (op == OP_ALU)         tos_nxt = din;
                        else if (depth == D_ONE)  tos_nxt = '0;
                        else                      tos_nxt = nos;
                        // Refill NOS from the array; below three entries the
                        // new NOS slot is empty and reads as zero.
                        if (depth > D_TWO) begin
                            nos_nxt = arr_rd;
                            sp_nxt  = sp - 1'b1;
                        end else begin
                            nos_nxt = '0;
                        end
                        depth_nxt = depth - D_ONE;
                    end
                    OP_REPL: begin
                        tos_nxt = din;
                    end
                    OP_SWAP: begin
                        tos_nxt = nos;
                        nos_nxt = tos;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos   <= '0;
            nos   <= '0;
            depth <= '0;
            hwm   <= '0;
            sp    <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            tos   <= tos_nxt;
            nos   <= nos_nxt;
            depth <= depth_nxt;
            hwm   <= max_depth(hwm, depth_nxt);
            sp    <= sp_nxt;
            // A new error takes priority over a simultaneous clear.
            if (ovf_hit)      ovf <= 1'b1;
            else if (err_clr) ovf <= 1'b0;
            if (udf_hit)      udf <= 1'b1;
            else if (err_clr) udf <= 1'b0;
        end
    end

    // Array contents need no reset: sp=0 after reset hides every entry.
    always_ff @(posedge clk) begin
        if (arr_we) arr[sp] <= nos;
    end

endmodule

// File: tb/tb_ej32_dstack.sv
module tb_ej32_dstack;

    localparam int DSZ = 32;
    localparam int SSD = 8;
    localparam int DW  = $clog2(SSD) + 1;

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] PUSH = 3'd1;
    localparam logic [2:0] POP  = 3'd2;
    localparam logic [2:0] ALU  = 3'd3;
    localparam logic [2:0] REPL = 3'd4;
    localparam logic [2:0] SWAP = 3'd5;
    localparam logic [2:0] DUP  = 3'd6;
    localparam logic [2:0] OVER = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Instance with HALT_ON_ERR=0
    logic           op_valid = 1'b0;
    logic           op_ready;
    logic [2:0]     op = NOP;
    logic [DSZ-1:0] din = '0;
    logic           err_clr = 1'b0;
    logic [DSZ-1:0] tos, nos;
    logic [DW-1:0]  depth, hwm;
    logic           full, empty, ovf, udf;

    // Instance with HALT_ON_ERR=1
    logic           h_op_valid = 1'b0;
    logic           h_op_ready;
    logic [2:0]     h_op = NOP;
    logic [DSZ-1:0] h_din = '0;
    logic           h_err_clr = 1'b0;
    logic [DSZ-1:0] h_tos, h_nos;
    logic [DW-1:0]  h_depth, h_hwm;
    logic           h_full, h_empty, h_ovf, h_udf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ej32_dstack #(.DSZ(DSZ), .SS_DEPTH(SSD), .HALT_ON_ERR(0)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .din(din), .err_clr(err_clr), .tos(tos), .nos(nos),
        .depth(depth), .hwm(hwm), .full(full), .empty(empty), .ovf(ovf), .udf(udf)
    );

    ej32_dstack #(.DSZ(DSZ), .SS_DEPTH(SSD), .HALT_ON_ERR(1)) dut_h (
        .clk(clk), .rst_n(rst_n), .op_valid(h_op_valid), .op_ready(h_op_ready),
        .op(h_op), .din(h_din), .err_clr(h_err_clr), .tos(h_tos), .nos(h_nos),
        .depth(h_depth), .hwm(h_hwm), .full(h_full), .empty(h_empty), .ovf(h_ovf), .udf(h_udf)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One op on the main instance; returns #1 after the accepting edge.
    task automatic step(input logic [2:0] o, input logic [DSZ-1:0] d);
        op_valid = 1'b1;
        op = o;
        din = d;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op = NOP;
    endtask

    task automatic clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic h_step(input logic [2:0] o, input logic [DSZ-1:0] d);
        h_op_valid = 1'b1;
        h_op = o;
        h_din = d;
        @(posedge clk);
        #1;
        h_op_valid = 1'b0;
        h_op = NOP;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_tos", tos, 0);
        chk("rst_nos", nos, 0);
        chk("rst_depth", 32'(depth), 0);
        chk("rst_hwm", 32'(hwm), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_flags", {30'd0, ovf, udf}, 0);
        chk("rst_ready", 32'(op_ready), 1);
        chk("rst_h_ready", 32'(h_op_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full
        for (int i = 1; i <= 8; i++) step(PUSH, DSZ'(i));
        chk("fill_tos", tos, 8);
        chk("fill_nos", nos, 7);
        chk("fill_depth", 32'(depth), 8);
        chk("fill_full", 32'(full), 1);
        chk("fill_hwm", 32'(hwm), 8);

        // Drain: tos 7..1 then 0
        step(POP, '0);
        chk("pop1_tos", tos, 7);
        chk("pop1_nos", nos, 6);
        for (int i = 6; i >= 1; i--) begin
            step(POP, '0);
            chk($sformatf("pop_tos_%0d", i), tos, 32'(i));
        end
        step(POP, '0);
        chk("drain_tos", tos, 0);
        chk("drain_nos", nos, 0);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_flags", {30'd0, ovf, udf}, 0);
        chk("drain_hwm", 32'(hwm), 8);

        // Overflow
        for (int i = 1; i <= 8; i++) step(PUSH, DSZ'(i));
        step(PUSH, 32'd9);
        chk("ovf_flag", 32'(ovf), 1);
        chk("ovf_tos", tos, 8);
        chk("ovf_nos", nos, 7);
        chk("ovf_depth", 32'(depth), 8);
        chk("ovf_ready", 32'(op_ready), 1);
        clr();
        chk("ovf_clr", 32'(ovf), 0);
        for (int i = 0; i < 8; i++) step(POP, '0);
        chk("ovf_drain_empty", 32'(empty), 1);
        chk("ovf_drain_udf", 32'(udf), 0);

        // ALU and underflow
        step(PUSH, 32'd5);
        step(PUSH, 32'd3);
        step(ALU, 32'd8);
        chk("alu_tos", tos, 8);
        chk("alu_nos", nos, 0);
        chk("alu_depth", 32'(depth), 1);
        step(ALU, 32'd99);
        chk("alu_udf", 32'(udf), 1);
        chk("alu_udf_tos", tos, 8);
        chk("alu_udf_depth", 32'(depth), 1);
        // Set wins over simultaneous clear
        op_valid = 1'b1; op = SWAP; err_clr = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0; op = NOP; err_clr = 1'b0;
        chk("set_wins_udf", 32'(udf), 1);
        clr();
        chk("udf_clr", 32'(udf), 0);
        step(POP, '0);
        chk("alu_pop_empty", 32'(empty), 1);

        // SWAP / OVER / DUP / REPL
        step(PUSH, 32'hA);
        step(PUSH, 32'hB);
        step(SWAP, '0);
        chk("swap_tos", tos, 32'hA);
        chk("swap_nos", nos, 32'hB);
        step(OVER, '0);
        chk("over_tos", tos, 32'hB);
        chk("over_nos", nos, 32'hA);
        chk("over_depth", 32'(depth), 3);
        step(DUP, '0);
        chk("dup_tos", tos, 32'hB);
        chk("dup_nos", nos, 32'hB);
        chk("dup_depth", 32'(depth), 4);
        step(REPL, 32'h77);
        chk("repl_tos", tos, 32'h77);
        chk("repl_depth", 32'(depth), 4);
        step(POP, '0);
        chk("mix_pop_tos", tos, 32'hB);
        chk("mix_pop_nos", nos, 32'hA);
        step(NOP, 32'h1234);
        chk("nop_tos", tos, 32'hB);
        chk("nop_depth", 32'(depth), 3);

        // Halt-on-error instance
        h_step(POP, '0);
        chk("h_udf", 32'(h_udf), 1);
        chk("h_ready_low", 32'(h_op_ready), 0);
        h_step(PUSH, 32'd7);
        chk("h_ignored_depth", 32'(h_depth), 0);
        chk("h_ignored_tos", h_tos, 0);
        h_err_clr = 1'b1;
        @(posedge clk);
        #1;
        h_err_clr = 1'b0;
        chk("h_ready_back", 32'(h_op_ready), 1);
        h_step(PUSH, 32'd7);
        chk("h_push_tos", h_tos, 7);
        chk("h_push_depth", 32'(h_depth), 1);

        // Asynchronous reset mid-sequence
        for (int i = 0; i < 3; i++) step(POP, '0);
        for (int i = 1; i <= 5; i++) step(PUSH, DSZ'(i));
        chk("pre_rst_tos", tos, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tos", tos, 0);
        chk("arst_nos", nos, 0);
        chk("arst_depth", 32'(depth), 0);
        chk("arst_hwm", 32'(hwm), 0);
        chk("arst_h_tos", h_tos, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(PUSH, 32'h55);
        chk("post_rst_tos", tos, 32'h55);
        chk("post_rst_depth", 32'(depth), 1);
        chk("post_rst_hwm", 32'(hwm), 1);
        chk("post_rst_nos", nos, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
